// File: rtl/rgb888_bayer_mosaic.sv
// RGB888 -> 8-bit Bayer RAW re-mosaic with one-cycle latency.
// Also checks frame geometry and reports the result once per frame.
module rgb888_bayer_mosaic #(
    parameter logic [10:0] IMG_HDISP     = 11'd640,
    parameter logic [10:0] IMG_VDISP     = 11'd480,
    parameter logic [1:0]  BAYER_PATTERN = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic [7:0] per_img_red,
    input  logic [7:0] per_img_green,
    input  logic [7:0] per_img_blue,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic [7:0] post_img_RAW,
    output logic       post_frame_done,
    output logic       post_line_err,
    output logic       post_frame_err
);

    localparam logic [10:0] IDX_MAX = 11'd2047;

    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  raw_q, raw_d;
    logic        done_q, done_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        line_acc_q, line_acc_d;
    logic [10:0] pix_q, pix_d;
    logic [10:0] line_q, line_d;

    logic        href_fall;
    logic        frame_end;
    logic        line_bad;
    logic [1:0]  phase;
    logic [10:0] pix_inc;
    logic [10:0] line_inc;
    logic [10:0] line_final;

    // The registered href/vsync copies double as the edge-detect history.
    always_comb begin
        href_fall  = href_q & ~per_frame_href;
        frame_end  = vsync_q & ~per_frame_vsync;
        line_bad   = (pix_q != IMG_HDISP);
        phase      = {line_q[0], pix_q[0]} ^ BAYER_PATTERN;
        pix_inc    = (pix_q == IDX_MAX) ? IDX_MAX : pix_q + 11'd1;
        line_inc   = (line_q == IDX_MAX) ? IDX_MAX : line_q + 11'd1;
        line_final = href_fall ? line_inc : line_q;

        vsync_d = per_frame_vsync;
        href_d  = per_frame_href;

        raw_d = 8'd0;
        if (per_frame_href) begin
            case (phase)
                2'b00:   raw_d = per_img_red;
                2'b11:   raw_d = per_img_blue;
                default: raw_d = per_img_green;
            endcase
        end

        pix_d = per_frame_href ? pix_inc : 11'd0;

        line_d = line_q;
        if (!per_frame_vsync) begin
            line_d = 11'd0;
        end else if (href_fall && vsync_q) begin
            line_d = line_inc;
        end

        done_d      = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        line_acc_d  = line_acc_q;
        // A line still open (or just closing) at frame end is checked before reporting.
        if (frame_end) begin
            done_d      = 1'b1;
            line_err_d  = line_acc_q | (href_q & line_bad);
            frame_err_d = (line_final != IMG_VDISP);
            line_acc_d  = 1'b0;
        end else if (href_fall && vsync_q && line_bad) begin
            line_acc_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            raw_q       <= 8'd0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            line_acc_q  <= 1'b0;
            pix_q       <= 11'd0;
            line_q      <= 11'd0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            raw_q       <= raw_d;
            done_q      <= done_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            line_acc_q  <= line_acc_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_img_RAW     = raw_q;
    assign post_frame_done  = done_q;
    assign post_line_err    = line_err_q;
    assign post_frame_err   = frame_err_q;

endmodule
